// File: rtl/opti_pkg.sv
// Shared widths and FSM encoding for the capture buffer.
package opti_pkg;

    localparam int OPTI_DATA_W = 24;
    localparam int OPTI_ADDR_W = 11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_e;

    // ARMED and CAPTURE own the buffer write port; IDLE and DONE own readback.
    function automatic logic is_active(cap_state_e s);
        return (s == ST_ARMED) || (s == ST_CAPTURE);
    endfunction

endpackage

// File: rtl/opti_capture_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
module opti_capture_ram
    import opti_pkg::*;
#(
    parameter int DATA_W = OPTI_DATA_W,
    parameter int ADDR_W = OPTI_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // NOTE: no reset on the array or its output register, so the tools can map it onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/opti_capture.sv
// Captures one run of filter output samples into a 2048-entry buffer and
// serves single-sample readback between runs, with run status and error flags.
module opti_capture
    import opti_pkg::*;
#(
    parameter int DATA_W = OPTI_DATA_W,
    parameter int ADDR_W = OPTI_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arm,
    input  logic                     cap_valid,
    input  logic [ADDR_W-1:0]        cap_addr,
    input  logic signed [DATA_W-1:0] cap_data,
    input  logic                     cap_stable,
    input  logic                     cap_done,
    input  logic                     rd_req,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic                     rd_ack,
    output logic signed [DATA_W-1:0] rd_data,
    output logic                     busy,
    output logic                     capture_done,
    output logic [ADDR_W:0]          sample_count,
    output logic [ADDR_W-1:0]        first_stable_addr,
    output logic                     stable_seen,
    output logic                     addr_err,
    output logic                     overrun_err
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(1 << ADDR_W);

    cap_state_e        state_q;
    logic [ADDR_W:0]   sample_count_q, sample_count_d;
    logic [ADDR_W-1:0] first_stable_q, first_stable_d;
    logic              stable_seen_q, stable_seen_d;
    logic              addr_err_q, addr_err_d;
    logic              overrun_err_q, overrun_err_d;
    logic              rd_ack_q;
    logic [DATA_W-1:0] rd_hold_q;
    logic [DATA_W-1:0] ram_rdata;

    logic active;
    logic buf_full;
    logic sample_take;
    logic overrun_hit;
    logic run_clear;
    logic rd_fire;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        active      = is_active(state_q);
        buf_full    = (sample_count_q == FULL_CNT);
        sample_take = cap_valid && active && !buf_full;
        overrun_hit = cap_valid && active && buf_full;
        run_clear   = arm && !active;
        rd_fire     = rd_req && !active;

        sample_count_d = sample_count_q;
        first_stable_d = first_stable_q;
        stable_seen_d  = stable_seen_q;
        addr_err_d     = addr_err_q;
        overrun_err_d  = overrun_err_q;

        if (run_clear) begin
            sample_count_d = '0;
            first_stable_d = '0;
            stable_seen_d  = 1'b0;
            addr_err_d     = 1'b0;
            overrun_err_d  = 1'b0;
        end else begin
            if (sample_take) begin
                sample_count_d = sample_count_q + 1'b1;
                if (cap_addr != sample_count_q[ADDR_W-1:0]) begin
                    addr_err_d = 1'b1;
                end
                if (cap_stable && !stable_seen_q) begin
                    stable_seen_d  = 1'b1;
                    first_stable_d = cap_addr;
                end
            end
            if (overrun_hit) begin
                overrun_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: if (arm)       state_q <= ST_ARMED;
                ST_ARMED:         if (cap_valid) state_q <= ST_CAPTURE;
                ST_CAPTURE:       if (cap_done)  state_q <= ST_DONE;
                default:                         state_q <= ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_count_q <= '0;
            first_stable_q <= '0;
            stable_seen_q  <= 1'b0;
            addr_err_q     <= 1'b0;
            overrun_err_q  <= 1'b0;
            rd_ack_q       <= 1'b0;
            rd_hold_q      <= '0;
        end else begin
            sample_count_q <= sample_count_d;
            first_stable_q <= first_stable_d;
            stable_seen_q  <= stable_seen_d;
            addr_err_q     <= addr_err_d;
            overrun_err_q  <= overrun_err_d;
            rd_ack_q       <= rd_fire;
            if (rd_ack_q) begin
                rd_hold_q <= ram_rdata;
            end
        end
    end

    // Writes are blocked while rst is high so a sample on the reset edge leaves no trace.
    opti_capture_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (sample_take && !rst),
        .waddr (cap_addr),
        .wdata (cap_data),
        .re    (rd_fire),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

    // The RAM output register cannot be reset, so a holding register supplies
    // the reset value and keeps the last read sample between acks.
    assign rd_data           = rd_ack_q ? ram_rdata : rd_hold_q;
    assign rd_ack            = rd_ack_q;
    assign busy              = active;
    assign capture_done      = (state_q == ST_DONE);
    assign sample_count      = sample_count_q;
    assign first_stable_addr = first_stable_q;
    assign stable_seen       = stable_seen_q;
    assign addr_err          = addr_err_q;
    assign overrun_err       = overrun_err_q;

endmodule

// File: tb/tb_opti_capture.sv
// Directed bench for opti_capture: a cycle-by-cycle vector table plus
// hand-written full-buffer, overrun, stable-latch and reset-abort sequences.
module tb_opti_capture;

    localparam int DW = 24;
    localparam int AW = 11;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 arm = 1'b0;
    logic                 cap_valid = 1'b0;
    logic [AW-1:0]        cap_addr = '0;
    logic signed [DW-1:0] cap_data = '0;
    logic                 cap_stable = 1'b0;
    logic                 cap_done = 1'b0;
    logic                 rd_req = 1'b0;
    logic [AW-1:0]        rd_addr = '0;
    logic                 rd_ack;
    logic signed [DW-1:0] rd_data;
    logic                 busy;
    logic                 capture_done;
    logic [AW:0]          sample_count;
    logic [AW-1:0]        first_stable_addr;
    logic                 stable_seen;
    logic                 addr_err;
    logic                 overrun_err;

    int total = 0;
    int bad   = 0;

    opti_capture dut (
        .clk               (clk),
        .rst               (rst),
        .arm               (arm),
        .cap_valid         (cap_valid),
        .cap_addr          (cap_addr),
        .cap_data          (cap_data),
        .cap_stable        (cap_stable),
        .cap_done          (cap_done),
        .rd_req            (rd_req),
        .rd_addr           (rd_addr),
        .rd_ack            (rd_ack),
        .rd_data           (rd_data),
        .busy              (busy),
        .capture_done      (capture_done),
        .sample_count      (sample_count),
        .first_stable_addr (first_stable_addr),
        .stable_seen       (stable_seen),
        .addr_err          (addr_err),
        .overrun_err       (overrun_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                 arm;
        logic                 valid;
        logic [AW-1:0]        addr;
        logic signed [DW-1:0] data;
        logic                 stable;
        logic                 done;
        logic                 rd;
        logic [AW-1:0]        raddr;
        logic                 e_busy;
        logic                 e_done;
        logic [AW:0]          e_count;
        logic                 e_aerr;
        logic                 e_stable;
        logic [AW-1:0]        e_fsa;
        logic                 e_ack;
        logic                 e_chk;
        logic signed [DW-1:0] e_data;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        arm = 1'b0; cap_valid = 1'b0; cap_stable = 1'b0; cap_done = 1'b0; rd_req = 1'b0;
    endtask

    task automatic sample(input int a, input int d, input logic st, input logic dn);
        cap_valid = 1'b1; cap_addr = AW'(a); cap_data = DW'(d); cap_stable = st; cap_done = dn;
        step();
        clear_inputs();
    endtask

    task automatic do_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic do_read(input int a, input int exp, input string name);
        rd_req = 1'b1; rd_addr = AW'(a);
        step();
        rd_req = 1'b0;
        check({name, "_ack"}, 32'(rd_ack), 32'd1);
        check({name, "_data"}, 32'(rd_data), 32'(exp));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        vecs[0]  = '{0,0,0,  0,0,0,0,0, 0,0,0,0,0,0, 0,0,0};
        vecs[1]  = '{1,0,0,  0,0,0,0,0, 1,0,0,0,0,0, 0,0,0};
        vecs[2]  = '{0,1,0, 10,0,0,0,0, 1,0,1,0,0,0, 0,0,0};
        vecs[3]  = '{0,1,1, -5,0,0,1,0, 1,0,2,0,0,0, 0,0,0};
        vecs[4]  = '{1,1,5, 77,0,0,0,0, 1,0,3,1,0,0, 0,0,0};
        vecs[5]  = '{0,1,3,  9,1,1,0,0, 0,1,4,1,1,3, 0,0,0};
        vecs[6]  = '{0,0,0,  0,0,0,1,5, 0,1,4,1,1,3, 1,1,77};
        vecs[7]  = '{0,0,0,  0,0,0,0,0, 0,1,4,1,1,3, 0,1,77};
        vecs[8]  = '{0,0,0,  0,0,0,1,1, 0,1,4,1,1,3, 1,1,-5};
        vecs[9]  = '{0,1,9,  1,1,0,0,0, 0,1,4,1,1,3, 0,0,0};
        vecs[10] = '{1,0,0,  0,0,0,0,0, 1,0,0,0,0,0, 0,0,0};
        vecs[11] = '{0,0,0,  0,0,1,0,0, 1,0,0,0,0,0, 0,0,0};
        vecs[12] = '{0,0,0,  0,0,0,1,0, 1,0,0,0,0,0, 0,0,0};

        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(capture_done), 32'd0);
        check("rst_count", 32'(sample_count), 32'd0);
        check("rst_ack", 32'(rd_ack), 32'd0);
        check("rst_data", 32'(rd_data), 32'd0);
        check("rst_flags", {29'd0, stable_seen, addr_err, overrun_err}, 32'd0);
        check("rst_fsa", 32'(first_stable_addr), 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 13; i++) begin
            arm = vecs[i].arm; cap_valid = vecs[i].valid; cap_addr = vecs[i].addr;
            cap_data = vecs[i].data; cap_stable = vecs[i].stable; cap_done = vecs[i].done;
            rd_req = vecs[i].rd; rd_addr = vecs[i].raddr;
            step();
            clear_inputs();
            check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            check($sformatf("v%0d_done", i), 32'(capture_done), 32'(vecs[i].e_done));
            check($sformatf("v%0d_count", i), 32'(sample_count), 32'(vecs[i].e_count));
            check($sformatf("v%0d_aerr", i), 32'(addr_err), 32'(vecs[i].e_aerr));
            check($sformatf("v%0d_stable", i), 32'(stable_seen), 32'(vecs[i].e_stable));
            check($sformatf("v%0d_fsa", i), 32'(first_stable_addr), 32'(vecs[i].e_fsa));
            check($sformatf("v%0d_ack", i), 32'(rd_ack), 32'(vecs[i].e_ack));
            if (vecs[i].e_chk) begin
                check($sformatf("v%0d_rdata", i), 32'(rd_data), 32'(vecs[i].e_data));
            end
        end

        // Stable latch: first stable on 37, another on 40.
        do_reset();
        do_arm();
        for (int i = 0; i < 45; i++) begin
            sample(i, i + 1000, (i == 37) || (i == 40), i == 44);
        end
        check("stab_seen", 32'(stable_seen), 32'd1);
        check("stab_fsa", 32'(first_stable_addr), 32'd37);
        check("stab_count", 32'(sample_count), 32'd45);
        check("stab_done", 32'(capture_done), 32'd1);

        // Reset asserted while sample 10 is presented aborts the run.
        do_arm();
        for (int i = 0; i < 10; i++) begin
            sample(i, i, 1'b0, 1'b0);
        end
        check("abort_pre_count", 32'(sample_count), 32'd10);
        cap_valid = 1'b1; cap_addr = AW'(10); cap_data = DW'(10); rst = 1'b1;
        step();
        clear_inputs();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_count", 32'(sample_count), 32'd0);
        check("abort_done", 32'(capture_done), 32'd0);
        step();
        check("abort_idle_busy", 32'(busy), 32'd0);

        // Full buffer with cap_done on the last sample.
        do_arm();
        for (int i = 0; i < 2048; i++) begin
            sample(i, i * 3, 1'b0, i == 2047);
        end
        check("full_done", 32'(capture_done), 32'd1);
        check("full_count", 32'(sample_count), 32'd2048);
        check("full_errs", {30'd0, addr_err, overrun_err}, 32'd0);
        do_read(100, 300, "full_rd100");
        do_read(2047, 6141, "full_rd2047");
        step();
        check("full_hold_ack", 32'(rd_ack), 32'd0);
        check("full_hold_data", 32'(rd_data), 32'd6141);

        // Overrun: one extra sample with the buffer full.
        do_arm();
        for (int i = 0; i < 2048; i++) begin
            sample(i, i * 3, 1'b0, 1'b0);
        end
        check("ovr_pre_err", 32'(overrun_err), 32'd0);
        sample(0, 12345, 1'b0, 1'b0);
        check("ovr_err", 32'(overrun_err), 32'd1);
        check("ovr_count", 32'(sample_count), 32'd2048);
        check("ovr_aerr", 32'(addr_err), 32'd0);
        cap_done = 1'b1;
        step();
        cap_done = 1'b0;
        check("ovr_done", 32'(capture_done), 32'd1);
        do_read(0, 0, "ovr_rd0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
